// File: rtl/key_conditioner.sv
// Key/switch front end for the shift-add multiplier: synchronises switches; synchronises, debounces
// and edge-detects the active-low Run and ClearA_LoadB keys. Define DEBOUNCE_EN to enable the counters.
module key_conditioner #(
    parameter int SW_WIDTH        = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run_n,
    input  logic                ClearA_LoadB_n,
    input  logic [SW_WIDTH-1:0] SW,
    output logic [SW_WIDTH-1:0] Din_sync,
    output logic                Run_pulse,
    output logic                ClearA_LoadB_pulse,
    output logic                Run_held
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("key_conditioner: need SYNC_STAGES >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    // Key index 0 = Run, 1 = ClearA_LoadB
    logic [1:0]             raw_n;
    logic [SYNC_STAGES-1:0] key_sync [2];
    logic [SW_WIDTH-1:0]    sw_sync  [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] valid_sr;
    logic                   sync_valid;
    logic [1:0]             synced_p;
    logic [1:0]             pressed;
    logic [1:0]             press_evt;
    logic [1:0]             armed;
    logic [1:0]             fire;

    assign raw_n = {ClearA_LoadB_n, Run_n};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int unsigned k = 0; k < 2; k++) key_sync[k] <= '1;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
            valid_sr <= '0;
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                key_sync[k][0] <= raw_n[k];
                for (int unsigned i = 1; i < SYNC_STAGES; i++) key_sync[k][i] <= key_sync[k][i-1];
            end
            sw_sync[0]  <= SW;
            valid_sr[0] <= 1'b1;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sw_sync[i]  <= sw_sync[i-1];
                valid_sr[i] <= valid_sr[i-1];
            end
        end
    end

    // The key flops reset to "released", so the synced value is only trusted once the chain has refilled
    assign sync_valid = valid_sr[SYNC_STAGES-1];
    assign Din_sync   = sw_sync[SYNC_STAGES-1];

    always_comb begin
        for (int unsigned k = 0; k < 2; k++) synced_p[k] = ~key_sync[k][SYNC_STAGES-1];
    end

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [2];

    always_comb begin
        for (int unsigned k = 0; k < 2; k++)
            press_evt[k] = synced_p[k] && !pressed[k] && (cnt[k] == CNT_LAST);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pressed <= '0;
            for (int unsigned k = 0; k < 2; k++) cnt[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (synced_p[k] == pressed[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    pressed[k] <= synced_p[k];
                    cnt[k]     <= '0;
                end else begin
                    cnt[k] <= cnt[k] + 1'b1;
                end
            end
        end
    end
`else
    assign press_evt = synced_p & ~pressed;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) pressed <= '0;
        else       pressed <= synced_p;
    end
`endif

    // A key arms only once it has genuinely been seen released, so a key held through reset cannot fire
    assign fire = press_evt & armed;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            armed              <= '0;
            Run_pulse          <= 1'b0;
            ClearA_LoadB_pulse <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < 2; k++)
                if (sync_valid && !synced_p[k] && !pressed[k]) armed[k] <= 1'b1;
            ClearA_LoadB_pulse <= fire[1];
            Run_pulse          <= fire[0] && !fire[1];
        end
    end

    assign Run_held = pressed[0] & armed[0];

endmodule
